// File: rtl/eclock_pkg.sv
// rtl/eclock_pkg.sv - shared defaults and peripheral-cycle state type for the E-clock generator
package eclock_pkg;

  // Defaults reproduce the legacy fixed divide-by-10 E clock (6 low / 4 high).
  localparam int DIV_DEFAULT      = 10;
  localparam int HIGH_DEFAULT     = 4;
  localparam int VMA_SLOT_DEFAULT = 2;

  // 6800-style synchronous peripheral cycle states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_VMA       = 2'd2,
    ST_DONE      = 2'd3
  } eclock_state_t;

endpackage

// File: rtl/eclock_divider.sv
// rtl/eclock_divider.sv - E-clock divider with registered phase strobes
module eclock_divider
  import eclock_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int HIGH  = HIGH_DEFAULT,
  localparam int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             eclock,
  output logic             e_rise,
  output logic             e_fall,
  output logic             latch,
  output logic [CNT_W-1:0] phase
);

  // Counter landmarks, sized to the counter so every compare is width-matched.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH  = CNT_W'(DIV - HIGH);
  localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] cnt;
  // High once the divider has completed one enabled edge; masks the E_FALL
  // that cnt == 0 would otherwise produce right after ENABLE rises.
  logic             running;

  // Counter, E and strobes all update together so they share one cycle of lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
      eclock  <= 1'b0;
      e_rise  <= 1'b0;
      e_fall  <= 1'b0;
      latch   <= 1'b0;
    end else if (!enable) begin
      cnt     <= '0;
      running <= 1'b0;
      eclock  <= 1'b0;
      e_rise  <= 1'b0;
      e_fall  <= 1'b0;
      latch   <= 1'b0;
    end else begin
      cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      running <= 1'b1;
      eclock  <= (cnt >= CNT_HIGH);
      e_rise  <= (cnt == CNT_HIGH);
      e_fall  <= (cnt == '0) && running;
      latch   <= (cnt == CNT_LATCH);
    end
  end

  assign phase = cnt;

endmodule

// File: rtl/eclock_sync_gen.sv
// rtl/eclock_sync_gen.sv - parametrised E-clock generator with VPA/VMA synchronous cycle
module eclock_sync_gen
  import eclock_pkg::*;
#(
  parameter int DIV      = DIV_DEFAULT,
  parameter int HIGH     = HIGH_DEFAULT,
  parameter int VMA_SLOT = VMA_SLOT_DEFAULT,
  localparam int CNT_W   = $clog2(DIV)
) (
  input  logic             CLOCK_IN,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             REQ,
  output logic             ECLOCK_OUT,
  output logic             E_RISE,
  output logic             E_FALL,
  output logic             LATCH,
  output logic             VMA_OUT,
  output logic             ACK,
  output logic [CNT_W-1:0] PHASE
);

  // Reject parameter sets that would give a degenerate or overlapping waveform.
  if (DIV < 4) begin : g_bad_div
    $error("eclock_sync_gen: DIV=%0d must be >= 4", DIV);
  end
  if (HIGH < 1 || HIGH > DIV - 2) begin : g_bad_high
    $error("eclock_sync_gen: HIGH=%0d must be in 1..DIV-2", HIGH);
  end
  if (VMA_SLOT < 0 || VMA_SLOT >= DIV - HIGH) begin : g_bad_slot
    $error("eclock_sync_gen: VMA_SLOT=%0d must be < DIV-HIGH", VMA_SLOT);
  end

  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(VMA_SLOT);

  logic [CNT_W-1:0] cnt;
  eclock_state_t    state;

  eclock_divider #(
    .DIV  (DIV),
    .HIGH (HIGH)
  ) u_divider (
    .clk    (CLOCK_IN),
    .rst_n  (RESET_N),
    .enable (ENABLE),
    .eclock (ECLOCK_OUT),
    .e_rise (E_RISE),
    .e_fall (E_FALL),
    .latch  (LATCH),
    .phase  (cnt)
  );

  assign PHASE = cnt;

  // Peripheral cycle: commit VMA at the slot, finish on the edge E falls.
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      VMA_OUT <= 1'b0;
      ACK     <= 1'b0;
    end else if (!ENABLE) begin
      state   <= ST_IDLE;
      VMA_OUT <= 1'b0;
      ACK     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            state <= ST_WAIT_SLOT;
          end
        end
        ST_WAIT_SLOT: begin
          // An abort wins over the slot: VMA is never shown for a dropped request.
          if (!REQ) begin
            state <= ST_IDLE;
          end else if (cnt == SLOT_CNT) begin
            state   <= ST_VMA;
            VMA_OUT <= 1'b1;
          end
        end
        ST_VMA: begin
          // Committed cycle: REQ is ignored until E falls.
          if (cnt == '0) begin
            state   <= ST_DONE;
            VMA_OUT <= 1'b0;
            ACK     <= 1'b1;
          end
        end
        ST_DONE: begin
          // Returning through IDLE enforces the REQ-low gap between cycles.
          if (!REQ) begin
            state <= ST_IDLE;
            ACK   <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          VMA_OUT <= 1'b0;
          ACK     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eclock_sync_gen.sv
// tb/tb_eclock_sync_gen.sv - randomized self-checking bench for eclock_sync_gen
module tb_eclock_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, req;

  logic       e0, r0, f0, l0, v0, a0;
  logic [3:0] p0;
  logic       e1, r1, f1, l1, v1, a1;
  logic [3:0] p1;

  eclock_sync_gen #(.DIV(10), .HIGH(4), .VMA_SLOT(2)) u_dut0 (
    .CLOCK_IN(clk), .RESET_N(rst_n), .ENABLE(en), .REQ(req),
    .ECLOCK_OUT(e0), .E_RISE(r0), .E_FALL(f0), .LATCH(l0),
    .VMA_OUT(v0), .ACK(a0), .PHASE(p0)
  );

  eclock_sync_gen #(.DIV(12), .HIGH(5), .VMA_SLOT(3)) u_dut1 (
    .CLOCK_IN(clk), .RESET_N(rst_n), .ENABLE(en), .REQ(req),
    .ECLOCK_OUT(e1), .E_RISE(r1), .E_FALL(f1), .LATCH(l1),
    .VMA_OUT(v1), .ACK(a1), .PHASE(p1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: n = enabled edges since ENABLE rose / reset released.
  int m_div [2] = '{10, 12};
  int m_high[2] = '{4, 5};
  int m_slot[2] = '{2, 3};
  int n   [2];
  bit pend[2];
  bit vma [2];
  bit ack [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; pend[i] = 0; vma[i] = 0; ack[i] = 0;
    end
  endfunction

  // Apply one clock edge with the given inputs.
  function automatic void model_edge(input bit e, input bit r);
    for (int i = 0; i < 2; i++) begin
      if (!e) begin
        n[i] = 0; pend[i] = 0; vma[i] = 0; ack[i] = 0;
      end else begin
        int pre;
        pre = n[i] % m_div[i];
        if (ack[i]) begin
          if (!r) ack[i] = 0;
        end else if (vma[i]) begin
          if (pre == 0) begin vma[i] = 0; ack[i] = 1; end
        end else if (pend[i]) begin
          if (!r) pend[i] = 0;
          else if (pre == m_slot[i]) begin pend[i] = 0; vma[i] = 1; end
        end else if (r) begin
          pend[i] = 1;
        end
        n[i]++;
      end
    end
  endfunction

  // Counter value that produced the currently visible registered outputs.
  function automatic int prev_cnt(input int i);
    return (n[i] - 1) % m_div[i];
  endfunction

  task automatic cmp_dut(input int i, input logic e, input logic rs, input logic fl,
                         input logic la, input logic vm, input logic ak, input logic [3:0] ph);
    int pc;
    pc = prev_cnt(i);
    check($sformatf("d%0d_eclock", i), int'(e),  int'(n[i] > 0 && pc >= m_div[i] - m_high[i]));
    check($sformatf("d%0d_e_rise", i), int'(rs), int'(n[i] > 0 && pc == m_div[i] - m_high[i]));
    check($sformatf("d%0d_e_fall", i), int'(fl), int'(n[i] > 1 && pc == 0));
    check($sformatf("d%0d_latch", i),  int'(la), int'(n[i] > 0 && pc == m_div[i] - 2));
    check($sformatf("d%0d_vma", i),    int'(vm), int'(vma[i]));
    check($sformatf("d%0d_ack", i),    int'(ak), int'(ack[i]));
    check($sformatf("d%0d_phase", i),  int'(ph), n[i] % m_div[i]);
  endtask

  task automatic cycle(input bit e, input bit r);
    en  = e;
    req = r;
    @(posedge clk);
    model_edge(e, r);
    @(negedge clk);
    cmp_dut(0, e0, r0, f0, l0, v0, a0, p0);
    cmp_dut(1, e1, r1, f1, l1, v1, a1, p1);
  endtask

  // Idle with REQ low until dut0 is idle and its next edge sees cnt == target.
  task automatic align0(input int target);
    int guard;
    guard = 0;
    while ((pend[0] || vma[0] || ack[0] || (n[0] % 10) != target) && guard < 100) begin
      cycle(1, 0);
      guard++;
    end
    check($sformatf("align_%0d_timeout", target), int'(guard < 100), 1);
  endtask

  int k, cnt_e0, cnt_e1, cnt_r0, cnt_f0, cnt_l0, cnt_v, cnt_a;
  int req_hold, en_hold;

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    cmp_dut(0, e0, r0, f0, l0, v0, a0, p0);
    cmp_dut(1, e1, r1, f1, l1, v1, a1, p1);
    rst_n = 1'b1;

    // Free-running waveform from reset release.
    cnt_e0 = 0; cnt_e1 = 0; cnt_r0 = 0; cnt_f0 = 0; cnt_l0 = 0;
    for (int c = 0; c < 60; c++) begin
      cycle(1, 0);
      if (c < 30) begin
        cnt_e0 += int'(e0); cnt_r0 += int'(r0); cnt_f0 += int'(f0); cnt_l0 += int'(l0);
      end
      cnt_e1 += int'(e1);
    end
    check("d0_e_high_30cyc", cnt_e0, 12);
    check("d0_rise_30cyc",   cnt_r0, 3);
    check("d0_fall_30cyc",   cnt_f0, 2);
    check("d0_latch_30cyc",  cnt_l0, 3);
    check("d1_e_high_60cyc", cnt_e1, 25);

    // REQ seen at cnt=0 and held: ACK at E fall, 11 edges later.
    align0(0);
    k = 0;
    while (k < 40 && a0 !== 1'b1) begin cycle(1, 1); k++; end
    check("lat_req_cnt0", k, 11);
    repeat (3) cycle(1, 1);
    cycle(1, 0);
    check("ack_clear_after_req", int'(a0), 0);

    // REQ seen at cnt=2: IDLE consumes the slot, so a full period is lost.
    align0(2);
    k = 0;
    while (k < 40 && a0 !== 1'b1) begin cycle(1, 1); k++; end
    check("lat_req_missed_slot", k, 19);
    cycle(1, 0);

    // Abort in WAIT_SLOT: VMA never asserts.
    align0(3);
    repeat (3) cycle(1, 1);
    cnt_v = 0;
    for (int c = 0; c < 12; c++) begin cycle(1, 0); cnt_v += int'(v0); end
    check("abort_no_vma", cnt_v, 0);

    // REQ dropped while VMA is high: cycle completes with a one-cycle ACK.
    align0(0);
    repeat (4) cycle(1, 1);
    check("vma_committed", int'(v0), 1);
    cnt_a = 0;
    for (int c = 0; c < 15; c++) begin cycle(1, 0); cnt_a += int'(a0); end
    check("ack_single_pulse", cnt_a, 1);

    // ENABLE dropped mid-VMA.
    align0(0);
    repeat (5) cycle(1, 1);
    cycle(0, 1);
    check("dis_vma", int'(v0), 0);
    check("dis_phase", int'(p0), 0);
    repeat (4) cycle(1, 0);

    // Asynchronous reset mid-VMA, away from any clock edge.
    align0(0);
    repeat (5) cycle(1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vma",   int'(v0), 0);
    check("arst_e",     int'(e0 | e1), 0);
    check("arst_phase", int'(p0) + int'(p1), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized REQ / ENABLE traffic.
    req_hold = 0; en_hold = 0;
    req = 1'b0; en = 1'b1;
    for (int c = 0; c < 900; c++) begin
      bit nr, ne;
      nr = req; ne = en;
      if (req_hold == 0) begin nr = ~req; req_hold = $urandom_range(1, 25); end
      else req_hold--;
      if (en_hold == 0) begin
        if (!en) begin ne = 1'b1; en_hold = $urandom_range(20, 80); end
        else begin ne = 1'b0; en_hold = $urandom_range(0, 3); end
      end else en_hold--;
      cycle(ne, nr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
